// File: rtl/stopwatch_controller.sv
// stopwatch_controller: MM:SS BCD stopwatch sequencer feeding a 4-digit seven-segment display.
// Define STOPWATCH_LAP_EN to build the lap-freeze snapshot path; otherwise the digits are always live.
module stopwatch_controller #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_dig1,
  output logic [3:0] sec_dig2,
  output logic [3:0] min_dig1,
  output logic [3:0] min_dig2,
  output logic       dp_on,
  output logic       running,
  output logic       wrap,
  output logic       lap_active
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_next;
  logic            w_tick;
  logic [3:0][3:0] r_cnt;
  logic [3:0][3:0] w_cnt_next;
  logic [3:0]      w_at_lim;
  logic [4:0]      w_carry;
  logic            r_running;
  logic            r_dp;
  logic            r_wrap;
  logic            w_dp_next;
  logic            w_wrap_next;
  logic [3:0][3:0] w_disp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // clear outranks start_stop; both outrank lap
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_IDLE;
    end else if (start_stop) begin
      case (r_state)
        S_IDLE:  w_state_next = S_RUN;
        S_RUN:   w_state_next = S_PAUSE;
        S_PAUSE: w_state_next = S_RUN;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign w_tick = (r_state == S_RUN) && (r_presc == PRESC_TOP);

  // PAUSE holds the fraction so a resume continues mid-second
  always_comb begin
    w_presc_next = r_presc;
    if (clear || (r_state == S_IDLE)) begin
      w_presc_next = '0;
    end else if (r_state == S_RUN) begin
      w_presc_next = w_tick ? '0 : r_presc + PW'(1);
    end
  end

  // Digit 0 = seconds units ... digit 3 = minutes tens; even digits roll at 9, odd at 5
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    localparam logic [3:0] LIM      = ((gi % 2) == 0) ? 4'd9 : 4'd5;
    localparam logic [3:0] LOW_MASK = 4'((1 << gi) - 1);

    assign w_at_lim[gi] = (r_cnt[gi] == LIM);
    assign w_carry[gi]  = w_tick && ((w_at_lim & LOW_MASK) == LOW_MASK);
    assign w_cnt_next[gi] = clear      ? 4'd0 :
                            w_carry[gi] ? (w_at_lim[gi] ? 4'd0 : r_cnt[gi] + 4'd1) :
                                          r_cnt[gi];
  end

  assign w_carry[4]  = w_tick && (&w_at_lim);
  assign w_wrap_next = w_carry[4] && !clear;

  // Status flags are computed from next-state values so they line up with the state register
  assign w_dp_next = (w_state_next == S_PAUSE) ||
                     ((w_state_next == S_RUN) && (w_presc_next >= PRESC_HALF));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc   <= '0;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_dp      <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_presc   <= w_presc_next;
      r_cnt     <= w_cnt_next;
      r_running <= (w_state_next == S_RUN);
      r_dp      <= w_dp_next;
      r_wrap    <= w_wrap_next;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic            r_hold;
  logic [3:0][3:0] r_snap;
  logic [3:0][3:0] r_disp;
  logic            w_lap_eff;
  logic            w_hold_next;
  logic [3:0][3:0] w_snap_next;
  logic [3:0][3:0] w_disp_next;

  assign w_lap_eff   = lap && !clear && !start_stop && (r_state == S_RUN);
  assign w_hold_next = clear ? 1'b0 : (w_lap_eff ? !r_hold : r_hold);
  // The snapshot is the value the live display would have shown on the freezing edge
  assign w_snap_next = (w_lap_eff && !r_hold) ? w_cnt_next : r_snap;
  assign w_disp_next = w_hold_next ? w_snap_next : w_cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= 1'b0;
      r_snap <= '0;
      r_disp <= '0;
    end else begin
      r_hold <= w_hold_next;
      r_snap <= w_snap_next;
      r_disp <= w_disp_next;
    end
  end

  assign w_disp     = r_disp;
  assign lap_active = r_hold;
`else
  logic w_unused_lap;

  assign w_unused_lap = lap;
  assign w_disp       = r_cnt;
  assign lap_active   = 1'b0;
`endif

  assign sec_dig1 = w_disp[0];
  assign sec_dig2 = w_disp[1];
  assign min_dig1 = w_disp[2];
  assign min_dig2 = w_disp[3];
  assign dp_on    = r_dp;
  assign running  = r_running;
  assign wrap     = r_wrap;

endmodule
